// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: op codes, control words, flag classes and FSM states for the ALU issue stage
package alu_ctrl_pkg;
   typedef enum logic [3:0] {
      OP_MOV, OP_ADD, OP_SUB, OP_OR, OP_NOT, OP_XOR, OP_AND, OP_INC,
      OP_DEC, OP_SLA, OP_SLL, OP_ROL, OP_SRA, OP_SRL, OP_ROR, OP_ILLEGAL
   } op_e;
   typedef enum logic [1:0] {CZ, Z_ONLY, NONE} fclass_e;
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
   // Encodings are tabulated C0 first; ctrl[i] drives Ctrl{i}, so bit order is reversed.
   function automatic logic [5:0] c0_first(input logic [5:0] s);
      return {s[0], s[1], s[2], s[3], s[4], s[5]};
   endfunction
   localparam logic [5:0] CTRL_MOV = c0_first(6'b000000);
   localparam logic [5:0] CTRL_ADD = c0_first(6'b010010);
   localparam logic [5:0] CTRL_SUB = c0_first(6'b010001);
   localparam logic [5:0] CTRL_OR  = c0_first(6'b001010);
   localparam logic [5:0] CTRL_NOT = c0_first(6'b001100);
   localparam logic [5:0] CTRL_XOR = c0_first(6'b001110);
   localparam logic [5:0] CTRL_AND = c0_first(6'b000110);
   localparam logic [5:0] CTRL_INC = c0_first(6'b011011);
   localparam logic [5:0] CTRL_DEC = c0_first(6'b011000);
   localparam logic [5:0] CTRL_SLA = c0_first(6'b100100);
   localparam logic [5:0] CTRL_SLL = c0_first(6'b100000);
   localparam logic [5:0] CTRL_ROL = c0_first(6'b100010);
   localparam logic [5:0] CTRL_SRA = c0_first(6'b101100);
   localparam logic [5:0] CTRL_SRL = c0_first(6'b101000);
   localparam logic [5:0] CTRL_ROR = c0_first(6'b101010);
endpackage

// File: rtl/alu_op_issue_if.sv
// alu_op_issue_if: op handshake, ALU flag feedback and decoder control lines
interface alu_op_issue_if;
   logic       op_valid;
   logic       op_ready;
   logic [3:0] op_code;
   logic [3:0] shamt;
   logic       alu_cout;
   logic       alu_zero;
   logic [5:0] ctrl;
   logic       c_flag;
   logic       z_flag;
   logic       alu_we;
   logic       done;
   logic       err;
   modport master (
      output op_valid, op_code, shamt, alu_cout, alu_zero,
      input  op_ready, ctrl, c_flag, z_flag, alu_we, done, err
   );
   modport slave (
      input  op_valid, op_code, shamt, alu_cout, alu_zero,
      output op_ready, ctrl, c_flag, z_flag, alu_we, done, err
   );
endinterface

// File: rtl/alu_op_encode.sv
// alu_op_encode: combinational op_code decode to control word, legality, shift flag and flag class
module alu_op_encode
   import alu_ctrl_pkg::*;
(
   input  op_e         op_code,
   output logic [5:0]  ctrl,
   output logic        legal,
   output logic        is_shift,
   output fclass_e     fclass
);
   // control word lookup; illegal codes decode to the idle word
   always_comb begin
      ctrl = CTRL_MOV;
      case (op_code)
         OP_ADD:  ctrl = CTRL_ADD;
         OP_SUB:  ctrl = CTRL_SUB;
         OP_OR:   ctrl = CTRL_OR;
         OP_NOT:  ctrl = CTRL_NOT;
         OP_XOR:  ctrl = CTRL_XOR;
         OP_AND:  ctrl = CTRL_AND;
         OP_INC:  ctrl = CTRL_INC;
         OP_DEC:  ctrl = CTRL_DEC;
         OP_SLA:  ctrl = CTRL_SLA;
         OP_SLL:  ctrl = CTRL_SLL;
         OP_ROL:  ctrl = CTRL_ROL;
         OP_SRA:  ctrl = CTRL_SRA;
         OP_SRL:  ctrl = CTRL_SRL;
         OP_ROR:  ctrl = CTRL_ROR;
         default: ctrl = CTRL_MOV;
      endcase
   end
   assign legal    = op_code != OP_ILLEGAL;
   assign is_shift = op_code inside {[OP_SLA:OP_ROR]};
   assign fclass   = (is_shift || op_code inside {OP_ADD, OP_SUB, OP_INC, OP_DEC}) ? CZ :
                     op_code inside {OP_OR, OP_NOT, OP_XOR, OP_AND} ? Z_ONLY : NONE;
endmodule

// File: rtl/alu_op_issue.sv
// alu_op_issue: issues one ALU op per handshake, repeats shift passes and owns the C/Z flags
module alu_op_issue
   import alu_ctrl_pkg::*;
(
   input logic          clk,
   input logic          rst,
   alu_op_issue_if.slave bus
);
   state_e     state, state_d;
   logic [3:0] n;
   logic [5:0] ctrl_q, ctrl_dec;
   fclass_e    fc_q, fc_dec;
   logic       err_q, legal, is_shift, c_q, z_q;
   alu_op_encode u_enc (
      .op_code  (op_e'(bus.op_code)),
      .ctrl     (ctrl_dec),
      .legal    (legal),
      .is_shift (is_shift),
      .fclass   (fc_dec)
   );
   // next state and outputs, decoded from registered state only
   always_comb begin
      state_d      = state == IDLE ? (bus.op_valid ? (legal ? EXEC : DONE) : IDLE) :
                     state == EXEC ? (n == 4'd1 ? DONE : EXEC) : IDLE;
      bus.op_ready = state == IDLE;
      bus.alu_we   = state == EXEC;
      bus.done     = state == DONE;
      bus.err      = state == DONE && err_q;
      bus.ctrl     = state == EXEC ? ctrl_q : CTRL_MOV;
      bus.c_flag   = c_q;
      bus.z_flag   = z_q;
   end
   // state, op latch at acceptance, pass countdown and per-pass flag capture
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         n      <= '0;
         ctrl_q <= '0;
         fc_q   <= NONE;
         err_q  <= 1'b0;
         c_q    <= 1'b0;
         z_q    <= 1'b0;
      end else begin
         state <= state_d;
         if (state == IDLE && bus.op_valid) begin
            n      <= (is_shift && bus.shamt != 4'd0) ? bus.shamt : 4'd1;
            ctrl_q <= ctrl_dec;
            fc_q   <= fc_dec;
            err_q  <= !legal;
         end
         if (state == EXEC) begin
            n   <= n - 4'd1;
            c_q <= fc_q == CZ ? bus.alu_cout : c_q;
            z_q <= fc_q != NONE ? bus.alu_zero : z_q;
         end
      end
   end
endmodule

// File: tb/tb_alu_op_issue.sv
// tb_alu_op_issue: randomized scoreboard bench for the ALU issue stage
module tb_alu_op_issue;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   alu_op_issue_if bus ();
   alu_op_issue dut (.clk(clk), .rst(rst), .bus(bus));
   typedef struct {
      logic [5:0]  ctrl;
      int          n;
      logic        err;
      logic [16:0] ch;
      logic [16:0] zh;
   } exp_t;
   exp_t q[$];
   exp_t cur;
   bit   active, ready_next;
   int   cnt, tests, fails;
   logic c_m, z_m;
   string ctrl_str [15] = '{"000000", "010010", "010001", "001010", "001100", "001110", "000110",
                            "011011", "011000", "100100", "100000", "100010", "101100", "101000", "101010"};
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h at %0t", nm, act, req, $time);
      end
   endtask
   function automatic logic [5:0] ctrl_of(input int op);
      logic [5:0] r;
      string s;
      r = '0;
      if (op < 15) begin
         s = ctrl_str[op];
         for (int i = 0; i < 6; i++) r[i] = s[i] == "1";
      end
      return r;
   endfunction
   function automatic bit writes_c(input int op);
      return op inside {1, 2, 7, 8} || (op >= 9 && op <= 14);
   endfunction
   function automatic bit writes_z(input int op);
      return writes_c(op) || op inside {3, 4, 5, 6};
   endfunction
   task automatic check_reset(input string nm);
      chk({nm, "_op_ready"}, 32'(bus.op_ready), 1);
      chk({nm, "_ctrl"}, 32'(bus.ctrl), 0);
      chk({nm, "_c_flag"}, 32'(bus.c_flag), 0);
      chk({nm, "_z_flag"}, 32'(bus.z_flag), 0);
      chk({nm, "_alu_we"}, 32'(bus.alu_we), 0);
      chk({nm, "_done"}, 32'(bus.done), 0);
      chk({nm, "_err"}, 32'(bus.err), 0);
   endtask
   task automatic issue(input int op, input int sh, input logic [15:0] cs, input logic [15:0] zs,
                        input bit hold, input int abort_pass);
      exp_t e;
      int   n, w;
      bit   ok;
      bus.op_valid = 1'b1;
      bus.op_code  = 4'(op);
      bus.shamt    = 4'(sh);
      bus.alu_cout = 1'($urandom);
      bus.alu_zero = 1'($urandom);
      w = 0;
      do begin
         @(negedge clk);
         ok = bus.op_ready;
         @(posedge clk);
         #1;
         w++;
      end while (!ok && w < 20);
      chk("accept_wait", 32'(w), 1);
      n = op == 15 ? 0 : (op >= 9 && op <= 14) ? (sh == 0 ? 1 : sh) : 1;
      e.ctrl  = ctrl_of(op);
      e.n     = n;
      e.err   = op == 15;
      e.ch    = '0;
      e.zh    = '0;
      e.ch[0] = c_m;
      e.zh[0] = z_m;
      for (int k = 0; k < n; k++) begin
         if (writes_c(op)) c_m = cs[k];
         if (writes_z(op)) z_m = zs[k];
         e.ch[k+1] = c_m;
         e.zh[k+1] = z_m;
      end
      q.push_back(e);
      bus.op_valid = hold;
      bus.op_code  = 4'($urandom);
      bus.shamt    = 4'($urandom);
      for (int k = 0; k < n; k++) begin
         bus.alu_cout = cs[k];
         bus.alu_zero = zs[k];
         if (k == abort_pass) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            bus.op_valid = 1'b0;
            c_m = 1'b0;
            z_m = 1'b0;
            @(negedge clk);
            check_reset("mid_reset");
            @(posedge clk);
            #1;
            return;
         end
         @(posedge clk);
         #1;
      end
      bus.alu_cout = 1'($urandom);
      bus.alu_zero = 1'($urandom);
      @(posedge clk);
      #1;
      bus.op_valid = 1'b0;
   endtask
   // monitor: pops the expected op when the DUT starts presenting it and checks every cycle
   always @(negedge clk) begin
      if (rst) begin
         active = 0;
         ready_next = 0;
         q.delete();
      end else begin
         chk("err_without_done", 32'(bus.err & ~bus.done), 0);
         if (ready_next) begin
            chk("ready_after_done", 32'(bus.op_ready), 1);
            chk("done_one_cycle", 32'(bus.done), 0);
            ready_next = 0;
         end
         if ((bus.alu_we || bus.done) && !active) begin
            if (q.size() == 0) begin
               chk("unexpected_activity", 32'({bus.alu_we, bus.done}), 0);
            end else begin
               cur = q.pop_front();
               active = 1;
               cnt = 0;
            end
         end
         if (active) begin
            if (bus.alu_we) begin
               chk("exec_ctrl", 32'(bus.ctrl), 32'(cur.ctrl));
               chk("exec_ready_low", 32'(bus.op_ready), 0);
               chk("pass_c_flag", 32'(bus.c_flag), 32'(cur.ch[cnt]));
               chk("pass_z_flag", 32'(bus.z_flag), 32'(cur.zh[cnt]));
               cnt++;
            end else if (bus.done) begin
               chk("pass_count", 32'(cnt), 32'(cur.n));
               chk("done_err", 32'(bus.err), 32'(cur.err));
               chk("done_c_flag", 32'(bus.c_flag), 32'(cur.ch[cur.n]));
               chk("done_z_flag", 32'(bus.z_flag), 32'(cur.zh[cur.n]));
               chk("done_ctrl", 32'(bus.ctrl), 0);
               chk("done_ready_low", 32'(bus.op_ready), 0);
               active = 0;
               ready_next = 1;
            end else begin
               chk("exec_gap", 0, 1);
               active = 0;
            end
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d tests %0d failed", tests, fails);
      $fatal(1);
   end
   initial begin
      rst = 1'b1;
      bus.op_valid = 1'b0;
      bus.op_code  = '0;
      bus.shamt    = '0;
      bus.alu_cout = 1'b0;
      bus.alu_zero = 1'b0;
      c_m = 1'b0;
      z_m = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset("reset");
      @(posedge clk);
      #1;
      issue(1, 0, 16'h0001, 16'h0000, 0, -1);
      issue(5, 0, 16'h0000, 16'h0001, 1, -1);
      issue(11, 5, 16'b10110, 16'b01001, 0, -1);
      issue(10, 0, 16'h0001, 16'h0000, 1, -1);
      issue(15, 3, 16'hffff, 16'h0000, 1, -1);
      issue(12, 4, 16'b1111, 16'b1111, 0, 1);
      issue(1, 0, 16'h0001, 16'h0001, 0, -1);
      repeat (40)
         issue($urandom_range(0, 15), $urandom_range(0, 15), 16'($urandom), 16'($urandom),
               1'($urandom), -1);
      repeat (3) @(posedge clk);
      chk("queue_drained", 32'(q.size()) + 32'(active), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/alu_op_issue.md
# alu_op_issue

Sequential issue stage directly upstream of the ALU control decoder in nlp-16a. Accepts one ALU operation per handshake from the instruction decoder, drives the six decoder control lines Ctrl0..Ctrl5 and the carry flag c_flag, and repeats single-bit shift and rotate passes for multi-bit shift counts. Owns the C and Z flag registers, updating them from the ALU's per-pass flag outputs, and signals completion to the sequencer.

## Interface
- No parameters. The datapath is fixed at 16 bits, and the 6-bit control word is fixed by the decoder.
- clk  in  1  system clock. One clock domain; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- op_valid  in  1  an operation is offered.
- op_ready  out  1  the block can accept an operation.
- op_code  in  4  operation index; see Operation.
- shamt  in  4  shift count. Used only by shift and rotate ops.
- alu_cout  in  1  ALU carry or shifted-out bit for the current pass.
- alu_zero  in  1  ALU result is zero for the current pass.
- ctrl  out  6  decoder controls. ctrl[i] drives Ctrl{i}.
- c_flag  out  1  carry flag register. Feeds the decoder's c_flag input.
- z_flag  out  1  zero flag register.
- alu_we  out  1  result writeback strobe, one per pass.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with done, for an illegal op_code.

## Operation
- Encoding: op_code maps to ctrl, written C0..C5.
  - 0 MOV 000000
  - 1 ADD 010010
  - 2 SUB 010001
  - 3 OR 001010
  - 4 NOT 001100
  - 5 XOR 001110
  - 6 AND 000110
  - 7 INC 011011
  - 8 DEC 011000
  - 9 SLA 100100
  - 10 SLL 100000
  - 11 ROL 100010
  - 12 SRA 101100
  - 13 SRL 101000
  - 14 ROR 101010
  - 15 illegal
- Flag update classes:
  - ADD, SUB, INC, DEC and ops 9-14 write both C and Z.
  - OR, NOT, XOR and AND write Z only.
  - MOV writes neither flag.
- States:
  - IDLE: op_ready=1, ctrl=000000, alu_we=0.
    - On op_valid&op_ready, latch op_code and shamt.
    - Load pass counter N: shamt for ops 9-14, with shamt=0 treated as 1; N=1 for all other ops.
    - Legal op_code: go to EXEC. op_code 15: go to DONE with err set.
  - EXEC: ctrl = the encoding, alu_we=1, op_ready=0.
    - Each cycle, capture flags per the op's class from alu_cout and alu_zero at the clock edge.
    - Decrement N. When N reaches 0, go to DONE.
    - Because c_flag updates every pass, rotates through carry chain correctly across passes.
  - DONE: done=1, err as latched, ctrl=000000, alu_we=0, op_ready=0. Next state is IDLE.
- op_code and shamt are sampled only at acceptance. Changes while busy are ignored.
- op_valid held in DONE is not accepted until IDLE.

## Timing
- All outputs are registered, or decoded from registered state only. No input-to-output combinational path.
- Reset values: op_ready=1, ctrl=000000, c_flag=0, z_flag=0, alu_we=0, done=0, err=0. State is IDLE.
- Reset mid-operation:
  - The next cycle shows reset values.
  - The in-flight op is abandoned with no done pulse.
  - Flags are cleared.
- Latency, with the op accepted at edge T:
  - EXEC occupies cycles T+1..T+N, with alu_we high for exactly N cycles.
  - done is high in cycle T+N+1.
  - op_ready returns in cycle T+N+2.
- Illegal op: done and err high in cycle T+1, with no alu_we.
- Throughput: one op per N+2 cycles.
- ctrl is stable for the whole EXEC window, including across shift passes.

## Structure
- Package alu_ctrl_pkg holds:
  - the op_code enum (0-14 plus ILLEGAL=15);
  - the 6-bit ctrl constants per op;
  - the flag-class enum (CZ, Z_ONLY, NONE);
  - the state enum (IDLE, EXEC, DONE).
- Sub-module alu_op_encode is combinational.
  - Input: op_code.
  - Outputs: ctrl, legal, is_shift, flag class.
  - The top holds the FSM, pass counter, op latch and flag registers.

## Test plan
- After reset: op_ready=1, ctrl=000000, c_flag=0, z_flag=0.
- ADD (op 1) with alu_cout=1, alu_zero=0:
  - ctrl=010010 and alu_we high for one cycle;
  - done the next cycle, then c_flag=1, z_flag=0.
- XOR (op 4's neighbour, op 5) after c_flag=1, with alu_cout=0, alu_zero=1: c_flag stays 1, z_flag=1, ctrl=001110.
- ROL (op 11) with shamt=5:
  - ctrl=100010 held for 5 cycles, alu_we high for exactly 5 cycles;
  - c_flag follows the alu_cout of each pass;
  - done in cycle T+6.
- SLL (op 10) with shamt=0: exactly 1 pass.
- op_code=15: done=1 and err=1 in cycle T+1, alu_we never asserted, flags unchanged.
- rst asserted in the 2nd pass of SRA (op 12) with shamt=4: the next cycle shows all reset values with no done; a new ADD is accepted immediately afterwards.
